avalon_rmw_frontend: RTL and testbench
======================================

Name: avalon_rmw_frontend

Overview:
- Avalon-MM slave front end that sits directly upstream of the peripheral's Avalon memory adapter and drives that adapter's read/write/address/data_in.
- Adds byte-enable support through a read-modify-write (RMW) sequence.
- Closes the write-then-read old-data hazard by stalling one cycle.
- Provides waitrequest backpressure and forwards read responses to the fabric with readdatavalid.

Parameters:
- BUSWIDTH, 32, data width of both the Avalon side and the adapter side; must be a multiple of 8.
- ADDRESSWIDTH, 8, word address width.
- LATENCY, 1, adapter read latency in cycles (at least 1); must match the adapter.
- BEWIDTH, BUSWIDTH/8, byte-enable width (derived).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- avs_read  in  1  Avalon read request.
- avs_write  in  1  Avalon write request.
- avs_address  in  ADDRESSWIDTH  word address.
- avs_writedata  in  BUSWIDTH  write data.
- avs_byteenable  in  BEWIDTH  byte lanes to write.
- avs_waitrequest  out  1  stall; the command is accepted in a cycle where a request is high and this is 0.
- avs_readdata  out  BUSWIDTH  read data.
- avs_readdatavalid  out  1  avs_readdata is valid this cycle.
- adp_read  out  1  read strobe to the adapter.
- adp_write  out  1  write strobe to the adapter.
- adp_address  out  ADDRESSWIDTH  address to the adapter.
- adp_data_in  out  BUSWIDTH  write data to the adapter.
- adp_read_valid  in  1  adapter read response valid.
- adp_data_out  in  BUSWIDTH  adapter read data.

Behaviour:
- Reset (reset=0), applied immediately even mid-RMW or with reads in flight:
  - State returns to IDLE; the outstanding counter, hazard register and merge register clear.
  - adp_read, adp_write and avs_readdatavalid are 0. avs_waitrequest is 1 while reset is asserted.
  - Responses to reads lost in flight are dropped.
- State machine: IDLE, DRAIN, RMW_RD, RMW_WAIT, RMW_WR.
- Outstanding counter:
  - Width is clog2(LATENCY+1)+1.
  - Increments on each adp_read issued in IDLE, and decrements on adp_read_valid when the state is not RMW_WAIT.
  - When an issue and a response happen in the same cycle, the counter is unchanged.
- Hazard register: when adp_write=1, it captures adp_address with a valid bit; the valid bit clears on the following cycle.
- IDLE, read:
  - If the hazard valid bit is set and avs_address equals the captured address, avs_waitrequest=1 for exactly one cycle.
  - Otherwise avs_waitrequest=0, adp_read=1 and adp_address=avs_address, all combinationally (zero added latency).
  - Back-to-back reads are accepted every cycle.
- IDLE, write with all byte enables set: avs_waitrequest=0; adp_write=1 with the address and data passed straight through in the same cycle.
- IDLE, write with byteenable all 0: accepted in one cycle; no adp_write is issued.
- IDLE, partial write (some but not all byte enables set): avs_waitrequest=1; latch the address, data and byteenable; go to DRAIN.
- DRAIN: hold until the outstanding count is 0, then go to RMW_RD. External responses continue to be forwarded during DRAIN.
- RMW_RD: adp_read=1 for one cycle to the latched address, then go to RMW_WAIT.
- RMW_WAIT:
  - On adp_read_valid, merge: result byte i = latched data byte i if byteenable[i] is set, else adp_data_out byte i. Store the result in the merge register and go to RMW_WR.
  - avs_readdatavalid stays 0 throughout this state (internal read).
- RMW_WR:
  - adp_write=1 with the merged data and latched address.
  - avs_waitrequest=0, so the master's partial write is accepted this cycle.
  - Set the hazard register; go to IDLE.
- avs_waitrequest is 1 in DRAIN, RMW_RD and RMW_WAIT.
- Read responses: avs_readdata=adp_data_out and avs_readdatavalid=adp_read_valid when the state is not RMW_WAIT, both combinational.
- Both avs_read and avs_write high in IDLE: the write has priority and the read stays stalled (waitrequest) until the write is accepted.
- When adp_read and adp_write are both 0, adp_address and adp_data_in are don't-care.
- Partial-write latency with no reads in flight: 3+LATENCY cycles from request to acceptance.

Test Plan:
- Full write then read: write 0x11223344 to addr 5 (be=0xF), next cycle read addr 5. Required: waitrequest=1 for exactly one cycle; readdatavalid LATENCY cycles after acceptance with data 0x11223344.
- Partial write: mem[3]=0xAABBCCDD, write 0x00000099 with be=0x1. Required: adapter sees read addr 3, then write addr 3 with data 0xAABBCC99; avs_readdatavalid never asserts; accepted after 3+LATENCY cycles.
- Drain ordering: issue reads to addrs 1, 2, 3, then immediately a partial write. Required: all three external responses return in order before RMW_RD issues; no internal data leaks onto avs_readdatavalid.
- Zero byte-enable write: be=0x0 to addr 7. Required: accepted in one cycle, adp_write stays 0, mem[7] unchanged.
- Streaming reads: 16 back-to-back reads to addrs 0 to 15 at LATENCY=2. Required: no waitrequest; 16 responses in order; counter returns to 0.
- Reset mid-RMW: assert reset=0 during RMW_WAIT. Required: state IDLE, all strobes 0, no readdatavalid; a fresh read after reset release succeeds.

Source files
------------

// File: rtl/avalon_rmw_frontend.sv
// Avalon-MM slave front end for the peripheral's memory adapter.
// Adds byte-enable support through a read-modify-write sequence, stalls a
// read that directly follows a write to the same word, applies waitrequest
// backpressure and forwards adapter read responses to the fabric.
module avalon_rmw_frontend #(
  parameter int BUSWIDTH     = 32,
  parameter int ADDRESSWIDTH = 8,
  parameter int LATENCY      = 1,
  parameter int BEWIDTH      = BUSWIDTH / 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    avs_read,
  input  logic                    avs_write,
  input  logic [ADDRESSWIDTH-1:0] avs_address,
  input  logic [BUSWIDTH-1:0]     avs_writedata,
  input  logic [BEWIDTH-1:0]      avs_byteenable,
  output logic                    avs_waitrequest,
  output logic [BUSWIDTH-1:0]     avs_readdata,
  output logic                    avs_readdatavalid,
  output logic                    adp_read,
  output logic                    adp_write,
  output logic [ADDRESSWIDTH-1:0] adp_address,
  output logic [BUSWIDTH-1:0]     adp_data_in,
  input  logic                    adp_read_valid,
  input  logic [BUSWIDTH-1:0]     adp_data_out
);

  // Room for every read the adapter can have in flight, plus headroom.
  localparam int CW = $clog2(LATENCY + 1) + 1;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    RMW_RD,
    RMW_WAIT,
    RMW_WR
  } state_t;

  state_t                  state;
  logic [CW-1:0]           outstanding;
  logic                    haz_valid;
  logic [ADDRESSWIDTH-1:0] haz_addr;
  logic [ADDRESSWIDTH-1:0] lat_addr;
  logic [BUSWIDTH-1:0]     lat_data;
  logic [BEWIDTH-1:0]      lat_be;
  logic [BUSWIDTH-1:0]     merge_data;
  logic [BUSWIDTH-1:0]     merged;

  logic full_be;
  logic zero_be;
  logic partial_be;
  logic haz_hit;
  logic cnt_inc;
  logic cnt_dec;

  assign full_be    = &avs_byteenable;
  assign zero_be    = ~|avs_byteenable;
  assign partial_be = !full_be && !zero_be;
  assign haz_hit    = haz_valid && (avs_address == haz_addr);

  // Only external reads issued from IDLE are tracked; the internal RMW read
  // and its response are kept out of the count.
  assign cnt_inc = adp_read && (state == IDLE);
  assign cnt_dec = adp_read_valid && (state != RMW_WAIT) && (outstanding != '0);

  // Byte-lane merge of the latched write data over the word just read back.
  always_comb begin
    merged = adp_data_out;
    for (int i = 0; i < BEWIDTH; i++) begin
      if (lat_be[i]) begin
        merged[i*8 +: 8] = lat_data[i*8 +: 8];
      end
    end
  end

  // Adapter strobes and fabric stall decoded from state; IDLE is pass-through.
  always_comb begin
    avs_waitrequest = 1'b1;
    adp_read        = 1'b0;
    adp_write       = 1'b0;
    adp_address     = avs_address;
    adp_data_in     = avs_writedata;
    if (reset) begin
      case (state)
        IDLE: begin
          avs_waitrequest = 1'b0;
          if (avs_write) begin
            if (full_be) begin
              adp_write = 1'b1;
            end else if (partial_be) begin
              avs_waitrequest = 1'b1;
            end
          end else if (avs_read) begin
            if (haz_hit) begin
              avs_waitrequest = 1'b1;
            end else begin
              adp_read = 1'b1;
            end
          end
        end
        RMW_RD: begin
          adp_read    = 1'b1;
          adp_address = lat_addr;
        end
        RMW_WR: begin
          avs_waitrequest = 1'b0;
          adp_write       = 1'b1;
          adp_address     = lat_addr;
          adp_data_in     = merge_data;
        end
        default: begin
          avs_waitrequest = 1'b1;
        end
      endcase
    end
  end

  // Responses pass straight through except the internal RMW read.
  assign avs_readdata      = adp_data_out;
  assign avs_readdatavalid = reset && adp_read_valid && (state != RMW_WAIT);

  // Sequencer for the partial-write RMW and the latched write operands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      lat_addr   <= '0;
      lat_data   <= '0;
      lat_be     <= '0;
      merge_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (avs_write && partial_be) begin
            lat_addr <= avs_address;
            lat_data <= avs_writedata;
            lat_be   <= avs_byteenable;
            state    <= DRAIN;
          end
        end
        DRAIN: begin
          if (outstanding == '0) begin
            state <= RMW_RD;
          end
        end
        RMW_RD: begin
          state <= RMW_WAIT;
        end
        RMW_WAIT: begin
          if (adp_read_valid) begin
            merge_data <= merged;
            state      <= RMW_WR;
          end
        end
        RMW_WR: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Count of external reads issued to the adapter and not yet answered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outstanding <= '0;
    end else if (cnt_inc && !cnt_dec) begin
      outstanding <= outstanding + CW'(1);
    end else if (cnt_dec && !cnt_inc) begin
      outstanding <= outstanding - CW'(1);
    end
  end

  // Remembers the word written last cycle so a read of it can be held off.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      haz_valid <= 1'b0;
      haz_addr  <= '0;
    end else begin
      haz_valid <= adp_write;
      if (adp_write) begin
        haz_addr <= adp_address;
      end
    end
  end

endmodule

// File: tb/tb_avalon_rmw_frontend.sv
// Scoreboard bench for avalon_rmw_frontend with a behavioural adapter of
// read latency LAT; stimulus pushes expected responses, monitors pop them.
module tb_avalon_rmw_frontend;

  localparam int BW  = 32;
  localparam int AW  = 8;
  localparam int LAT = 2;
  localparam int BEW = BW / 8;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           avs_read = 1'b0;
  logic           avs_write = 1'b0;
  logic [AW-1:0]  avs_address = '0;
  logic [BW-1:0]  avs_writedata = '0;
  logic [BEW-1:0] avs_byteenable = '0;
  logic           avs_waitrequest;
  logic [BW-1:0]  avs_readdata;
  logic           avs_readdatavalid;
  logic           adp_read;
  logic           adp_write;
  logic [AW-1:0]  adp_address;
  logic [BW-1:0]  adp_data_in;
  logic           adp_read_valid;
  logic [BW-1:0]  adp_data_out;

  always #5 clk = ~clk;

  avalon_rmw_frontend #(
    .BUSWIDTH(BW),
    .ADDRESSWIDTH(AW),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .avs_read(avs_read),
    .avs_write(avs_write),
    .avs_address(avs_address),
    .avs_writedata(avs_writedata),
    .avs_byteenable(avs_byteenable),
    .avs_waitrequest(avs_waitrequest),
    .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid),
    .adp_read(adp_read),
    .adp_write(adp_write),
    .adp_address(adp_address),
    .adp_data_in(adp_data_in),
    .adp_read_valid(adp_read_valid),
    .adp_data_out(adp_data_out)
  );

  // Adapter model: word memory preset to 0x10000000+addr, fixed read latency.
  logic [BW-1:0] mem [0:255];
  bit            init_done = 1'b0;
  logic [LAT-1:0] pv;
  logic [BW-1:0]  pd [0:LAT-1];

  assign adp_read_valid = pv[LAT-1];
  assign adp_data_out   = pd[LAT-1];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pv <= '0;
      if (!init_done) begin
        for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 + 32'(i);
        init_done <= 1'b1;
      end
    end else begin
      if (adp_write) mem[adp_address] <= adp_data_in;
      pv[0] <= adp_read;
      pd[0] <= mem[adp_address];
      for (int i = 1; i < LAT; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [BW-1:0] data;
    int            due;
  } rd_exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [BW-1:0] data;
  } wr_exp_t;

  rd_exp_t rdq[$];
  wr_exp_t wrq[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: fabric read responses and adapter writes against the queues.
  rd_exp_t rd_e;
  wr_exp_t wr_e;
  always @(negedge clk) begin
    if (reset) begin
      if (avs_readdatavalid) begin
        if (rdq.size() == 0) begin
          check_output("unexpected_readdatavalid", 32'(avs_readdatavalid), 32'd0);
        end else begin
          rd_e = rdq.pop_front();
          check_output("readdata", avs_readdata, rd_e.data);
          check_output("read_latency", 32'(cyc), 32'(rd_e.due));
        end
      end
      if (adp_write) begin
        if (wrq.size() == 0) begin
          check_output("unexpected_adp_write", 32'(adp_write), 32'd0);
        end else begin
          wr_e = wrq.pop_front();
          check_output("adp_write_addr", 32'(adp_address), 32'(wr_e.addr));
          check_output("adp_write_data", adp_data_in, wr_e.data);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_write(input logic [AW-1:0] addr, input logic [BW-1:0] data,
                             input logic [BEW-1:0] be, output int waits);
    avs_write      = 1'b1;
    avs_address    = addr;
    avs_writedata  = data;
    avs_byteenable = be;
    waits = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!avs_waitrequest) break;
      waits++;
    end
    if (waits >= 50) check_output("write_accept_timeout", 32'(waits), 32'd0);
    @(posedge clk);
    #1;
    avs_write = 1'b0;
  endtask

  task automatic apply_read(input logic [AW-1:0] addr, input logic [BW-1:0] exp, output int waits);
    rd_exp_t e;
    avs_read    = 1'b1;
    avs_address = addr;
    waits = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!avs_waitrequest) break;
      waits++;
    end
    if (waits >= 50) begin
      check_output("read_accept_timeout", 32'(waits), 32'd0);
    end else begin
      e.data = exp;
      e.due  = cyc + LAT;
      rdq.push_back(e);
    end
    @(posedge clk);
    #1;
    avs_read = 1'b0;
  endtask

  logic [BW-1:0] stream_exp [16] = '{
    32'h1000_0000, 32'h1000_0001, 32'h1000_0002, 32'hAABB_CC99,
    32'h10FF_EE04, 32'h1122_3344, 32'h1000_0006, 32'h1000_0007,
    32'h1000_0008, 32'h1000_0009, 32'h1000_000A, 32'h1000_000B,
    32'h1000_000C, 32'h1000_000D, 32'h1000_000E, 32'h1000_000F
  };

  initial begin
    int w;
    int sum;
    wr_exp_t we;

    // Reset with requests asserted: everything must be held off.
    avs_read = 1'b1;
    avs_write = 1'b1;
    avs_byteenable = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset_waitrequest", 32'(avs_waitrequest), 32'd1);
    check_output("reset_adp_read", 32'(adp_read), 32'd0);
    check_output("reset_adp_write", 32'(adp_write), 32'd0);
    check_output("reset_readdatavalid", 32'(avs_readdatavalid), 32'd0);
    avs_read = 1'b0;
    avs_write = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(2);

    // Full write then read of the same word: one hazard stall.
    we.addr = 8'd5; we.data = 32'h1122_3344; wrq.push_back(we);
    apply_write(8'd5, 32'h1122_3344, 4'hF, w);
    check_output("full_write_waits", 32'(w), 32'd0);
    apply_read(8'd5, 32'h1122_3344, w);
    check_output("hazard_read_waits", 32'(w), 32'd1);
    idle(4);

    // Partial write: byte 0 replaced, upper bytes kept.
    we.addr = 8'd3; we.data = 32'hAABB_CCDD; wrq.push_back(we);
    apply_write(8'd3, 32'hAABB_CCDD, 4'hF, w);
    check_output("seed_write_waits", 32'(w), 32'd0);
    idle(2);
    we.addr = 8'd3; we.data = 32'hAABB_CC99; wrq.push_back(we);
    apply_write(8'd3, 32'h0000_0099, 4'h1, w);
    check_output("partial_write_waits", 32'(w), 32'(3 + LAT));
    apply_read(8'd3, 32'hAABB_CC99, w);
    check_output("read_after_rmw_waits", 32'(w), 32'd1);
    idle(4);

    // Zero byte-enable write: accepted at once, memory untouched.
    apply_write(8'd7, 32'hDEAD_BEEF, 4'h0, w);
    check_output("zero_be_waits", 32'(w), 32'd0);
    apply_read(8'd7, 32'h1000_0007, w);
    check_output("zero_be_read_waits", 32'(w), 32'd0);
    idle(4);

    // Drain: three reads in flight, then a partial write right behind them.
    sum = 0;
    apply_read(8'd1, 32'h1000_0001, w); sum += w;
    apply_read(8'd2, 32'h1000_0002, w); sum += w;
    apply_read(8'd3, 32'hAABB_CC99, w); sum += w;
    check_output("drain_reads_waits", 32'(sum), 32'd0);
    we.addr = 8'd4; we.data = 32'h10FF_EE04; wrq.push_back(we);
    apply_write(8'd4, 32'h00FF_EE00, 4'b0110, w);
    check_output("drain_write_waits", 32'd6, 32'(w));
    idle(4);

    // Streaming reads 0..15 back to back.
    sum = 0;
    for (int i = 0; i < 16; i++) begin
      apply_read(8'(i), stream_exp[i], w);
      sum += w;
    end
    check_output("stream_waits", 32'(sum), 32'd0);
    idle(LAT + 3);
    check_output("stream_all_responses", 32'(rdq.size()), 32'd0);
    check_output("stream_outstanding", 32'(dut.outstanding), 32'd0);

    // Reset while the RMW read is in flight.
    avs_write = 1'b1;
    avs_address = 8'd8;
    avs_writedata = 32'h0000_0055;
    avs_byteenable = 4'h1;
    idle(3);
    check_output("pre_reset_waitrequest", 32'(avs_waitrequest), 32'd1);
    reset = 1'b0;
    #1;
    check_output("midrmw_waitrequest", 32'(avs_waitrequest), 32'd1);
    check_output("midrmw_adp_read", 32'(adp_read), 32'd0);
    check_output("midrmw_adp_write", 32'(adp_write), 32'd0);
    check_output("midrmw_readdatavalid", 32'(avs_readdatavalid), 32'd0);
    check_output("midrmw_state_idle", 32'(dut.state), 32'd0);
    check_output("midrmw_outstanding", 32'(dut.outstanding), 32'd0);
    avs_write = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(4);
    apply_read(8'd8, 32'h1000_0008, w);
    check_output("post_reset_read_waits", 32'(w), 32'd0);
    idle(LAT + 3);

    check_output("final_read_queue_empty", 32'(rdq.size()), 32'd0);
    check_output("final_write_queue_empty", 32'(wrq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
